// File: rtl/slv_wresp_gen.sv
// Slave-side AXI write-response generator.
// Queues accepted AW requests, counts W beats against the head AWLEN,
// accumulates beat-write errors and produces one B response per burst.
// Build option: define WRESP_DECERR_EN to enable address decode (DECERR for
// AWADDR above ADDR_LIMIT); when undefined, m_AWADDR_i is ignored.
module slv_wresp_gen #(
  parameter int                TRANS_SLV_ID_W  = 7,
  parameter int                TRANS_WR_RESP_W = 2,
  parameter int                OUTSTANDING_AMT = 8,
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT      = ADDR_W'(32'h0000_FFFF)
) (
  input  logic                              ACLK_i,
  input  logic                              ARESETn_i,
  input  logic [TRANS_SLV_ID_W-1:0]         m_AWID_i,
  input  logic [ADDR_W-1:0]                 m_AWADDR_i,
  input  logic [7:0]                        m_AWLEN_i,
  input  logic                              m_AWVALID_i,
  output logic                              m_AWREADY_o,
  input  logic                              m_WLAST_i,
  input  logic                              m_WVALID_i,
  output logic                              m_WREADY_o,
  input  logic                              mem_err_i,
  output logic [TRANS_SLV_ID_W-1:0]         m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]        m_BRESP_o,
  output logic                              m_BVALID_o,
  input  logic                              m_BREADY_i,
  output logic [$clog2(OUTSTANDING_AMT):0]  outst_cnt_o
);

  localparam int PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING_AMT);
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_OKAY   = TRANS_WR_RESP_W'(2'b00);
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_SLVERR = TRANS_WR_RESP_W'(2'b10);
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_DECERR = TRANS_WR_RESP_W'(2'b11);

  logic [TRANS_SLV_ID_W-1:0] fifo_id  [OUTSTANDING_AMT];
  logic [7:0]                fifo_len [OUTSTANDING_AMT];
  logic                      fifo_dec [OUTSTANDING_AMT];

  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic                       aw_ready_q;
  logic                       aw_empty;
  logic                       aw_push;
  logic                       aw_decerr;
  logic                       w_hs;
  logic                       w_last_hs;
  logic [7:0]                 beat_cnt;
  logic                       err_sticky;
  logic                       len_err_sticky;
  logic [TRANS_SLV_ID_W-1:0]  head_id;
  logic [7:0]                 head_len;
  logic                       head_dec;
  logic [TRANS_WR_RESP_W-1:0] resp_next;

`ifdef WRESP_DECERR_EN
  assign aw_decerr = (m_AWADDR_i > ADDR_LIMIT);
`else
  logic unused_addr;
  assign unused_addr = ^{m_AWADDR_i, ADDR_LIMIT};
  assign aw_decerr   = 1'b0;
`endif

  // Status comes from the registered count, so a fresh push is never
  // poppable in the cycle it arrives.
  assign aw_empty    = (cnt == '0);
  assign aw_push     = m_AWVALID_i & aw_ready_q;
  assign m_AWREADY_o = aw_ready_q;
  assign m_WREADY_o  = ~aw_empty & (~m_BVALID_o | m_BREADY_i);
  assign w_hs        = m_WVALID_i & m_WREADY_o;
  assign w_last_hs   = w_hs & m_WLAST_i;
  assign outst_cnt_o = cnt;

  assign head_id  = fifo_id[rd_ptr];
  assign head_len = fifo_len[rd_ptr];
  assign head_dec = fifo_dec[rd_ptr];

  // Next occupancy and the response code for the burst completing this cycle.
  always_comb begin
    cnt_next  = cnt + CNT_W'(aw_push) - CNT_W'(w_last_hs);
    resp_next = RESP_OKAY;
    if (head_dec)
      resp_next = RESP_DECERR;
    else if (err_sticky || mem_err_i || len_err_sticky || (beat_cnt != head_len))
      resp_next = RESP_SLVERR;
  end

  // AW entry storage; contents are meaningless until the pointers cover them.
  always_ff @(posedge ACLK_i) begin
    if (aw_push) begin
      fifo_id[wr_ptr]  <= m_AWID_i;
      fifo_len[wr_ptr] <= m_AWLEN_i;
      fifo_dec[wr_ptr] <= aw_decerr;
    end
  end

  // Queue pointers, beat tracking, error accumulation and the B register.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      aw_ready_q     <= 1'b0;
      beat_cnt       <= '0;
      err_sticky     <= 1'b0;
      len_err_sticky <= 1'b0;
      m_BVALID_o     <= 1'b0;
      m_BID_o        <= '0;
      m_BRESP_o      <= '0;
    end else begin
      if (aw_push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (w_last_hs) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt        <= cnt_next;
      aw_ready_q <= (cnt_next != FULL_CNT);

      if (w_hs) begin
        if (m_WLAST_i) begin
          beat_cnt       <= '0;
          err_sticky     <= 1'b0;
          len_err_sticky <= 1'b0;
        end else begin
          beat_cnt       <= beat_cnt + 8'd1;
          err_sticky     <= err_sticky | mem_err_i;
          len_err_sticky <= len_err_sticky | (beat_cnt == head_len);
        end
      end

      // WREADY already guarantees the B slot is free or draining this cycle.
      if (w_last_hs) begin
        m_BVALID_o <= 1'b1;
        m_BID_o    <= head_id;
        m_BRESP_o  <= resp_next;
      end else if (m_BREADY_i) begin
        m_BVALID_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slv_wresp_gen.sv
// Directed testbench for slv_wresp_gen (default parameters).
module tb_slv_wresp_gen;

  typedef struct {
    logic        awvalid;
    logic [6:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wlast;
    logic        mem_err;
    logic        bready;
    logic        e_awready;
    logic        e_wready;
    logic        e_bvalid;
    logic [6:0]  e_bid;
    logic [1:0]  e_bresp;
    logic [3:0]  e_cnt;
  } vec_t;

`ifdef WRESP_DECERR_EN
  localparam logic [1:0] EXP_HIADDR = 2'b11;
`else
  localparam logic [1:0] EXP_HIADDR = 2'b00;
`endif

  logic        clk;
  logic        rst_n;
  logic [6:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        mem_err;
  logic [6:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  cnt;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  slv_wresp_gen dut (
    .ACLK_i      (clk),
    .ARESETn_i   (rst_n),
    .m_AWID_i    (awid),
    .m_AWADDR_i  (awaddr),
    .m_AWLEN_i   (awlen),
    .m_AWVALID_i (awvalid),
    .m_AWREADY_o (awready),
    .m_WLAST_i   (wlast),
    .m_WVALID_i  (wvalid),
    .m_WREADY_o  (wready),
    .mem_err_i   (mem_err),
    .m_BID_o     (bid),
    .m_BRESP_o   (bresp),
    .m_BVALID_o  (bvalid),
    .m_BREADY_i  (bready),
    .outst_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t v(logic awv, logic [6:0] id, logic [31:0] addr, logic [7:0] len,
                             logic wv, logic wl, logic me, logic br,
                             logic e_awr, logic e_wr, logic e_bv, logic [6:0] e_bid,
                             logic [1:0] e_bresp, logic [3:0] e_cnt);
    vec_t r;
    r.awvalid = awv; r.awid = id; r.awaddr = addr; r.awlen = len;
    r.wvalid = wv; r.wlast = wl; r.mem_err = me; r.bready = br;
    r.e_awready = e_awr; r.e_wready = e_wr; r.e_bvalid = e_bv;
    r.e_bid = e_bid; r.e_bresp = e_bresp; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 0; wlast = 0; mem_err = 0; bready = 1;
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, then let the edge happen.
  task automatic run_vec(input vec_t x, input string tag);
    awvalid = x.awvalid; awid = x.awid; awaddr = x.awaddr; awlen = x.awlen;
    wvalid = x.wvalid; wlast = x.wlast; mem_err = x.mem_err; bready = x.bready;
    @(negedge clk);
    check({tag, ".awready"}, 32'(awready), 32'(x.e_awready));
    check({tag, ".wready"},  32'(wready),  32'(x.e_wready));
    check({tag, ".bvalid"},  32'(bvalid),  32'(x.e_bvalid));
    check({tag, ".cnt"},     32'(cnt),     32'(x.e_cnt));
    if (x.e_bvalid) begin
      check({tag, ".bid"},   32'(bid),   32'(x.e_bid));
      check({tag, ".bresp"}, 32'(bresp), 32'(x.e_bresp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, ".bvalid"},  32'(bvalid),  32'd0);
    check({tag, ".bid"},     32'(bid),     32'd0);
    check({tag, ".bresp"},   32'(bresp),   32'd0);
    check({tag, ".wready"},  32'(wready),  32'd0);
    check({tag, ".awready"}, 32'(awready), 32'd0);
    check({tag, ".cnt"},     32'(cnt),     32'd0);
  endtask

  initial begin
    // Continuous directed table:     awv id    addr          len wv wl me br | awr wr bv bid  resp cnt
    // Single clean burst, 4 beats.
    tbl.push_back(v(1, 7'h15, 32'h0,          3, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 1, 7'h15, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    // mem_err on beat 2 of 4, then a clean burst.
    tbl.push_back(v(1, 7'h22, 32'h0,          3, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 1, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(1, 7'h23, 32'h0,          1, 0, 0, 0, 1, 1, 0, 1, 7'h22, 2'b10, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 1, 7'h23, 2'b00, 0));
    // AWLEN=1 but WLAST on first beat, then a high address.
    tbl.push_back(v(1, 7'h31, 32'h0,          1, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(1, 7'h32, 32'h0001_0000,  0, 0, 0, 0, 1, 1, 0, 1, 7'h31, 2'b10, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 1, 7'h32, EXP_HIADDR, 0));
    // Beat count reaches AWLEN without WLAST.
    tbl.push_back(v(1, 7'h40, 32'h0,          0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 1, 7'h40, 2'b10, 0));
    // mem_err only on the last beat.
    tbl.push_back(v(1, 7'h41, 32'h0,          0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 1, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 1, 7'h41, 2'b10, 0));
    // BREADY low 5 cycles with two bursts queued, then back-to-back B.
    tbl.push_back(v(1, 7'h50, 32'h0,          0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    tbl.push_back(v(1, 7'h51, 32'h0,          0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1));
    tbl.push_back(v(1, 7'h52, 32'h0,          0, 1, 1, 0, 0, 1, 0, 1, 7'h50, 2'b00, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 7'h00, 32'h0,        0, 1, 1, 0, 0, 1, 0, 1, 7'h50, 2'b00, 2));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 1, 7'h50, 2'b00, 2));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 1, 1, 1, 1, 7'h51, 2'b00, 1));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 1, 7'h52, 2'b00, 0));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0));
    // Fill the queue with 8 AWs, 9th stalls until the first pop.
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(1, 7'(8'h60 + i), 32'h0, 0, 0, 0, 0, 1, 1, (i > 0), 0, 7'h00, 2'b00, 4'(i)));
    tbl.push_back(v(1, 7'h68, 32'h0,          0, 0, 0, 0, 1, 0, 1, 0, 7'h00, 2'b00, 8));
    tbl.push_back(v(1, 7'h68, 32'h0,          0, 1, 1, 0, 1, 0, 1, 0, 7'h00, 2'b00, 8));
    tbl.push_back(v(1, 7'h68, 32'h0,          0, 0, 0, 0, 1, 1, 1, 1, 7'h60, 2'b00, 7));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 0, 0, 0, 1, 0, 1, 0, 7'h00, 2'b00, 8));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 0, 0, 0, 1, 0, 7'h00, 2'b00, 8));
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 1, 0, 0, 0, 1, 0, 7'h00, 2'b00, 8));
    // Start a burst mid-way (one beat, with error) right before reset.
    tbl.push_back(v(0, 7'h00, 32'h0,          0, 1, 0, 1, 1, 1, 1, 1, 7'h61, 2'b10, 7));

    // Reset state.
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check_in_reset("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(v(0, 7'h00, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h00, 2'b00, 0), "rel0");

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Asynchronous reset mid-burst with 7 entries queued.
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_in_reset("rst1");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(v(0, 7'h00, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h00, 2'b00, 0), "rel1");
    // Beat counter and sticky errors must not leak into the next burst.
    run_vec(v(1, 7'h70, 32'h0, 1, 0, 0, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0), "post0");
    run_vec(v(0, 7'h00, 32'h0, 0, 1, 0, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1), "post1");
    run_vec(v(0, 7'h00, 32'h0, 0, 1, 1, 0, 1, 1, 1, 0, 7'h00, 2'b00, 1), "post2");
    run_vec(v(1, 7'h71, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 7'h70, 2'b00, 0), "post3");
    run_vec(v(0, 7'h00, 32'h0, 0, 1, 1, 0, 0, 1, 0, 1, 7'h70, 2'b00, 1), "post4");

    // Reset with a pending B and a queued entry: nothing emerges afterwards.
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_in_reset("rst2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(v(0, 7'h00, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h00, 2'b00, 0), "rel2");
    for (int i = 0; i < 3; i++)
      run_vec(v(0, 7'h00, 32'h0, 0, 1, 1, 0, 1, 1, 0, 0, 7'h00, 2'b00, 0), $sformatf("quiet%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slv_wresp_gen.md
SLV_WRESP_GEN -- requirements
Module: slv_wresp_gen

Interface
REQ-001 SHALL have parameter TRANS_SLV_ID_W, default 7, meaning the width of the slave-side transaction ID.
REQ-002 SHALL have parameter TRANS_WR_RESP_W, default 2, meaning the BRESP width.
REQ-003 SHALL have parameter OUTSTANDING_AMT, default 8, meaning the AW queue depth (power of 2).
REQ-004 SHALL have parameter ADDR_W, default 32, meaning the AWADDR width.
REQ-005 SHALL have parameter ADDR_LIMIT, default 32'h0000_FFFF, meaning the highest decodable address.
REQ-006 SHALL have port ACLK_i, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port ARESETn_i, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have AW ports: m_AWID_i (in, TRANS_SLV_ID_W), m_AWADDR_i (in, ADDR_W), m_AWLEN_i (in, 8), m_AWVALID_i (in, 1) and m_AWREADY_o (out, 1).
REQ-009 SHALL have W ports: m_WLAST_i (in, 1), m_WVALID_i (in, 1), m_WREADY_o (out, 1) and mem_err_i (in, 1, beat-write error from storage).
REQ-010 SHALL have B ports: m_BID_o (out, TRANS_SLV_ID_W), m_BRESP_o (out, TRANS_WR_RESP_W), m_BVALID_o (out, 1) and m_BREADY_i (in, 1).
REQ-011 SHALL have port outst_cnt_o, output, clog2(OUTSTANDING_AMT)+1 bits: the number of AW entries queued.

Function
REQ-012 SHALL push {AWID, AWLEN, decerr} into the AW FIFO on AWVALID&AWREADY; m_AWREADY_o = ~full.
REQ-013 SHALL assert m_WREADY_o = ~aw_empty & (~m_BVALID_o | m_BREADY_i), using registered FIFO status, so there is no same-cycle AW-to-W bypass.
REQ-014 SHALL increment an 8-bit beat counter on each W handshake and clear it on a WLAST handshake.
REQ-015 SHALL OR mem_err_i into a sticky error flag on each W handshake; the flag clears on a WLAST handshake.
REQ-016 SHALL flag a length error when WLAST arrives with beat count != head AWLEN, or when beat count == AWLEN without WLAST.
REQ-017 SHALL, on a WLAST handshake, pop the AW FIFO and load the B register with BVALID high on the next edge (latency 1 cycle).
REQ-018 SHALL set BRESP to 2'b11 DECERR if the head decerr bit is set (see REQ-028), else 2'b10 SLVERR if the sticky error, the last-beat mem_err_i or the length error is set, else 2'b00 OKAY.
REQ-019 SHALL hold m_BID_o, m_BRESP_o and m_BVALID_o stable while BVALID=1 and BREADY=0, and deassert BVALID after the handshake unless reloaded in the same cycle.
REQ-020 SHALL reload B in the same cycle that a BREADY handshake and a WLAST handshake coincide (back-to-back responses with no bubble).
REQ-021 SHALL handle a simultaneous push and pop: a full FIFO stays full-count-correct, but AWREADY stays low that cycle; with an empty FIFO, a push is not poppable until the next cycle.
REQ-022 SHALL wrap FIFO pointers modulo OUTSTANDING_AMT; outst_cnt_o tracks pushes minus pops exactly.

Reset
REQ-023 SHALL, while ARESETn_i=0, force m_BVALID_o=0, m_BID_o=0, m_BRESP_o=0, m_WREADY_o=0 and outst_cnt_o=0.
REQ-024 SHALL hold m_AWREADY_o=0 while in reset and drive it to 1 at the first edge after release.
REQ-025 SHALL, on reset mid-burst, discard all FIFO entries, the beat counter, the sticky error and any pending B without emitting a response.
REQ-026 SHALL apply reset asynchronously on assertion, with synchronous release at the next ACLK_i edge.

Configuration
REQ-027 SHALL use the macro WRESP_DECERR_EN to control address decode.
REQ-028 SHALL, with WRESP_DECERR_EN defined, store decerr = (AWADDR > ADDR_LIMIT) per AW; that burst's W beats are accepted and dropped, and BRESP is DECERR.
REQ-029 SHALL, without WRESP_DECERR_EN, tie decerr to 0, so no DECERR is ever produced and m_AWADDR_i is unused.

Verification
REQ-030 SHALL cover: AWID=7'h15, AWLEN=3, 4 W beats with WLAST on the 4th, BREADY=1 -> BID=7'h15, BRESP=OKAY, BVALID for 1 cycle, 1 cycle after WLAST.
REQ-031 SHALL cover: mem_err_i=1 on beat 2 of 4 -> BRESP=2'b10; the next clean burst returns OKAY (sticky cleared).
REQ-032 SHALL cover: 8 AWs with no W -> outst_cnt_o=8, AWREADY=0; the 9th AW stalls until the first WLAST pops.
REQ-033 SHALL cover: BREADY=0 for 5 cycles with two bursts queued -> WREADY=0, B held stable; BREADY=1 gives back-to-back B in consecutive cycles.
REQ-034 SHALL cover: AWLEN=1 with WLAST on beat 1 -> SLVERR; with WRESP_DECERR_EN, AWADDR=32'h0001_0000 -> BRESP=2'b11.
REQ-035 SHALL cover: ARESETn_i low mid-burst -> BVALID=0 and outst_cnt_o=0 immediately; no response is issued after release.
